// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants, encodings and types for the multi-cycle RV32I control unit.
package ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ALU_W  = 4;

  // RV32I major opcodes handled by this unit
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALU operation encodings
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1001;

  // Write-back and PC source selects
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Trap cause codes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_NONE   = 3'd6
  } iclass_e;

  // Decoder result bundle
  typedef struct packed {
    iclass_e          iclass;
    logic [ALU_W-1:0] alu_ctrl;
    logic             alu_src;
    logic             legal;
    logic             br_inv;
  } dec_t;

  // Branches whose taken condition is the inverse of alu_zero: BNE, BLT, BLTU
  function automatic logic branch_invert(input logic [2:0] funct3);
    return funct3[2] ? ~funct3[0] : funct3[0];
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction handshake, datapath status and control-strobe bundle.
interface multicycle_ctrl_fsm_if;
  import ctrl_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [XLEN-1:0]   instruction;
  logic              alu_zero;
  logic              mem_ready;
  logic              trap_clear;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [ALU_W-1:0]  alu_ctrl;
  logic              alu_src;
  logic              mem_req;
  logic              mem_we;
  logic              rf_wen;
  logic [1:0]        wb_sel;
  logic              pc_wen;
  logic [1:0]        pc_sel;
  logic              trap;
  logic [1:0]        trap_cause;
  logic [CNT_W-1:0]  instret;

  // Datapath / fetch side
  modport master (
    output instr_valid, instruction, alu_zero, mem_ready, trap_clear,
    input  instr_ready, rs1_addr, rs2_addr, rd_addr, alu_ctrl, alu_src,
           mem_req, mem_we, rf_wen, wb_sel, pc_wen, pc_sel, trap, trap_cause, instret
  );

  // Control unit side
  modport slave (
    input  instr_valid, instruction, alu_zero, mem_ready, trap_clear,
    output instr_ready, rs1_addr, rs2_addr, rd_addr, alu_ctrl, alu_src,
           mem_req, mem_we, rf_wen, wb_sel, pc_wen, pc_sel, trap, trap_cause, instret
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_decoder.sv
// Combinational instruction decoder: class, ALU op/operand select, legality.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  logic f7_zero;
  logic f7_alt;

  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // Map opcode/funct fields onto the control class and ALU operation
  always_comb begin
    dec.iclass   = CLS_NONE;
    dec.alu_ctrl = ALU_ADD;
    dec.alu_src  = 1'b0;
    dec.legal    = 1'b0;
    dec.br_inv   = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec.iclass = CLS_R;
        dec.legal  = f7_zero;
        unique case (funct3)
          3'b000: begin
            dec.alu_ctrl = f7_alt ? ALU_SUB : ALU_ADD;
            dec.legal    = f7_zero | f7_alt;
          end
          3'b001: dec.alu_ctrl = ALU_SLL;
          3'b010: dec.alu_ctrl = ALU_SLT;
          3'b011: dec.alu_ctrl = ALU_SLTU;
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            dec.alu_ctrl = f7_alt ? ALU_SRA : ALU_SRL;
            dec.legal    = f7_zero | f7_alt;
          end
          3'b110: dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec.iclass  = CLS_I;
        dec.alu_src = 1'b1;
        dec.legal   = 1'b1;
        unique case (funct3)
          3'b000: dec.alu_ctrl = ALU_ADD;
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            dec.legal    = f7_zero;
          end
          3'b010: dec.alu_ctrl = ALU_SLT;
          3'b011: dec.alu_ctrl = ALU_SLTU;
          3'b100: dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            dec.alu_ctrl = f7_alt ? ALU_SRA : ALU_SRL;
            dec.legal    = f7_zero | f7_alt;
          end
          3'b110: dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        dec.iclass  = CLS_LOAD;
        dec.alu_src = 1'b1;
        dec.legal   = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        dec.iclass  = CLS_STORE;
        dec.alu_src = 1'b1;
        dec.legal   = (funct3 inside {3'b000, 3'b001, 3'b010});
      end
      OPC_BRANCH: begin
        dec.iclass   = CLS_BRANCH;
        dec.legal    = !(funct3 inside {3'b010, 3'b011});
        dec.br_inv   = branch_invert(funct3);
        dec.alu_ctrl = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
      end
      OPC_JAL: begin
        dec.iclass  = CLS_JAL;
        dec.alu_src = 1'b1;
        dec.legal   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control unit: IDLE->DECODE->EXEC->[MEM]->WB with trap and retire count.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_ctrl_fsm_if.slave bus
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [1:0]        trap_cause_q, trap_cause_d;

  logic              instr_ready;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [ALU_W-1:0]  alu_ctrl;
  logic              alu_src;
  logic              mem_req;
  logic              mem_we;
  logic              rf_wen;
  logic [1:0]        wb_sel;
  logic              pc_wen;
  logic [1:0]        pc_sel;
  logic              retire;
  logic              in_flight;
  logic [REG_AW-1:0] ir_rd;
  dec_t              dec;

  assign ir_rd     = ir_q[11:7];
  assign in_flight = (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB});

  ctrl_decoder u_decoder (
    .opcode (ir_q[6:0]),
    .funct3 (ir_q[14:12]),
    .funct7 (ir_q[31:25]),
    .dec    (dec)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction, wait counter, retire counter and trap cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q         <= '0;
      wait_cnt_q   <= '0;
      instret_q    <= '0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      ir_q         <= ir_d;
      wait_cnt_q   <= wait_cnt_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    wait_cnt_d   = wait_cnt_q;
    trap_cause_d = trap_cause_q;
    instret_d    = instret_q;
    retire       = 1'b0;
    instr_ready  = 1'b0;
    rs1_addr     = '0;
    rs2_addr     = '0;
    rd_addr      = '0;
    alu_ctrl     = ALU_ADD;
    alu_src      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    rf_wen       = 1'b0;
    wb_sel       = WB_ALU;
    pc_wen       = 1'b0;
    pc_sel       = PC_PLUS4;

    // Register addresses and ALU controls stay stable while an instruction is in flight
    if (in_flight) begin
      rs1_addr = ir_q[19:15];
      rs2_addr = ir_q[24:20];
      rd_addr  = ir_rd;
      alu_ctrl = dec.alu_ctrl;
      alu_src  = dec.alu_src;
    end

    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) begin
          ir_d    = bus.instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!dec.legal) begin
          trap_cause_d = CAUSE_ILLEGAL;
          state_d      = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unique case (dec.iclass)
          CLS_BRANCH: begin
            pc_wen  = 1'b1;
            pc_sel  = (bus.alu_zero ^ dec.br_inv) ? PC_BRANCH : PC_PLUS4;
            retire  = 1'b1;
            state_d = ST_IDLE;
          end
          CLS_LOAD, CLS_STORE: begin
            wait_cnt_d = '0;
            state_d    = ST_MEM;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec.iclass == CLS_STORE);
        if (bus.mem_ready) begin
          if (dec.iclass == CLS_STORE) begin
            pc_wen  = 1'b1;
            pc_sel  = PC_PLUS4;
            retire  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
          trap_cause_d = CAUSE_MEM_TO;
          state_d      = ST_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ST_WB: begin
        rf_wen = (ir_rd != '0);
        unique case (dec.iclass)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  wb_sel = WB_PC4;
          default:  wb_sel = WB_ALU;
        endcase
        pc_wen  = 1'b1;
        pc_sel  = (dec.iclass == CLS_JAL) ? PC_JUMP : PC_PLUS4;
        retire  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_TRAP: begin
        if (bus.trap_clear) begin
          trap_cause_d = CAUSE_NONE;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.rs1_addr    = rs1_addr;
  assign bus.rs2_addr    = rs2_addr;
  assign bus.rd_addr     = rd_addr;
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.alu_src     = alu_src;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.rf_wen      = rf_wen;
  assign bus.wb_sel      = wb_sel;
  assign bus.pc_wen      = pc_wen;
  assign bus.pc_sel      = pc_sel;
  assign bus.trap        = (state_q == ST_TRAP);
  assign bus.trap_cause  = trap_cause_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: expected values are hand-derived per step.
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next sample point (1 unit after the falling edge)
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Offer an instruction in IDLE; returns at the DECODE sample point
  task automatic send(input logic [31:0] instr);
    bus.instr_valid = 1'b1;
    bus.instruction = instr;
    #1;
    chk("ready_in_idle", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
  endtask

  // Pulse trap_clear from TRAP and land in IDLE
  task automatic clear_trap();
    bus.trap_clear = 1'b1;
    nxt();
    bus.trap_clear = 1'b0;
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.alu_zero    = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.trap_clear  = 1'b0;
    #2;
    chk("rst_ready",   32'(bus.instr_ready), 32'd1);
    chk("rst_rf_wen",  32'(bus.rf_wen), 32'd0);
    chk("rst_pc_wen",  32'(bus.pc_wen), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_trap",    32'(bus.trap), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_rs1",     32'(bus.rs1_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ADD x3,x1,x2
    send(32'h002081B3);
    chk("add_dec_rs1",   32'(bus.rs1_addr), 32'd1);
    chk("add_dec_rs2",   32'(bus.rs2_addr), 32'd2);
    chk("add_dec_ready", 32'(bus.instr_ready), 32'd0);
    chk("add_dec_rfwen", 32'(bus.rf_wen), 32'd0);
    nxt();
    chk("add_exec_alu",  32'(bus.alu_ctrl), 32'd0);
    chk("add_exec_src",  32'(bus.alu_src), 32'd0);
    chk("add_exec_pcw",  32'(bus.pc_wen), 32'd0);
    nxt();
    chk("add_wb_rfwen",  32'(bus.rf_wen), 32'd1);
    chk("add_wb_rd",     32'(bus.rd_addr), 32'd3);
    chk("add_wb_sel",    32'(bus.wb_sel), 32'd0);
    chk("add_wb_pcw",    32'(bus.pc_wen), 32'd1);
    chk("add_wb_instret", bus.instret, 32'd0);
    nxt();
    chk("add_idle_ready", 32'(bus.instr_ready), 32'd1);
    chk("add_instret",    bus.instret, 32'd1);

    // BNE x1,x2 taken (alu_zero=0)
    send(32'h00209463);
    nxt();
    bus.alu_zero = 1'b0;
    #1;
    chk("bne_t_alu",   32'(bus.alu_ctrl), 32'(ALU_SUB));
    chk("bne_t_pcw",   32'(bus.pc_wen), 32'd1);
    chk("bne_t_pcsel", 32'(bus.pc_sel), 32'd1);
    chk("bne_t_rfwen", 32'(bus.rf_wen), 32'd0);
    nxt();
    chk("bne_t_ready",   32'(bus.instr_ready), 32'd1);
    chk("bne_t_instret", bus.instret, 32'd2);

    // BNE x1,x2 not taken (alu_zero=1)
    send(32'h00209463);
    nxt();
    bus.alu_zero = 1'b1;
    #1;
    chk("bne_nt_pcw",   32'(bus.pc_wen), 32'd1);
    chk("bne_nt_pcsel", 32'(bus.pc_sel), 32'd0);
    nxt();
    bus.alu_zero = 1'b0;
    chk("bne_nt_instret", bus.instret, 32'd3);

    // BGE x1,x2 with alu_zero=1 -> taken
    send(32'h0020D463);
    nxt();
    bus.alu_zero = 1'b1;
    #1;
    chk("bge_alu",   32'(bus.alu_ctrl), 32'(ALU_SLT));
    chk("bge_pcsel", 32'(bus.pc_sel), 32'd1);
    nxt();
    bus.alu_zero = 1'b0;
    chk("bge_instret", bus.instret, 32'd4);

    // LW x5,0(x1), mem_ready on third MEM cycle
    send(32'h0000A283);
    nxt();
    chk("lw_exec_src", 32'(bus.alu_src), 32'd1);
    chk("lw_exec_alu", 32'(bus.alu_ctrl), 32'd0);
    chk("lw_exec_req", 32'(bus.mem_req), 32'd0);
    nxt();
    chk("lw_mem1_req", 32'(bus.mem_req), 32'd1);
    chk("lw_mem1_we",  32'(bus.mem_we), 32'd0);
    nxt();
    chk("lw_mem2_req", 32'(bus.mem_req), 32'd1);
    nxt();
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_mem3_req", 32'(bus.mem_req), 32'd1);
    chk("lw_mem3_pcw", 32'(bus.pc_wen), 32'd0);
    nxt();
    bus.mem_ready = 1'b0;
    #1;
    chk("lw_wb_req",   32'(bus.mem_req), 32'd0);
    chk("lw_wb_rfwen", 32'(bus.rf_wen), 32'd1);
    chk("lw_wb_rd",    32'(bus.rd_addr), 32'd5);
    chk("lw_wb_sel",   32'(bus.wb_sel), 32'd1);
    nxt();
    chk("lw_instret", bus.instret, 32'd5);

    // SW x2,0(x1) with no mem_ready -> timeout trap after 16 MEM cycles
    send(32'h0020A023);
    nxt();
    nxt();
    chk("sw_mem1_req", 32'(bus.mem_req), 32'd1);
    chk("sw_mem1_we",  32'(bus.mem_we), 32'd1);
    for (int i = 2; i <= 16; i++) nxt();
    chk("sw_mem16_req",  32'(bus.mem_req), 32'd1);
    chk("sw_mem16_trap", 32'(bus.trap), 32'd0);
    nxt();
    chk("sw_to_trap",  32'(bus.trap), 32'd1);
    chk("sw_to_cause", 32'(bus.trap_cause), 32'd2);
    chk("sw_to_req",   32'(bus.mem_req), 32'd0);
    chk("sw_to_ready", 32'(bus.instr_ready), 32'd0);
    nxt();
    chk("sw_to_hold", 32'(bus.trap), 32'd1);
    clear_trap();
    chk("sw_clr_trap",    32'(bus.trap), 32'd0);
    chk("sw_clr_cause",   32'(bus.trap_cause), 32'd0);
    chk("sw_clr_ready",   32'(bus.instr_ready), 32'd1);
    chk("sw_clr_instret", bus.instret, 32'd5);

    // SW with mem_ready in the final allowed cycle completes normally
    send(32'h0020A023);
    nxt();
    nxt();
    for (int i = 2; i <= 16; i++) nxt();
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_last_pcw",   32'(bus.pc_wen), 32'd1);
    chk("sw_last_pcsel", 32'(bus.pc_sel), 32'd0);
    nxt();
    bus.mem_ready = 1'b0;
    chk("sw_last_trap",    32'(bus.trap), 32'd0);
    chk("sw_last_instret", bus.instret, 32'd6);

    // Illegal opcode 0x7F
    send(32'h0000007F);
    nxt();
    chk("ill_trap",  32'(bus.trap), 32'd1);
    chk("ill_cause", 32'(bus.trap_cause), 32'd1);
    bus.instr_valid = 1'b1;
    nxt();
    chk("ill_ready_blocked", 32'(bus.instr_ready), 32'd0);
    chk("ill_still_trap",    32'(bus.trap), 32'd1);
    bus.instr_valid = 1'b0;
    clear_trap();
    chk("ill_clr_ready",   32'(bus.instr_ready), 32'd1);
    chk("ill_clr_instret", bus.instret, 32'd6);

    // Unsupported funct7 on OP (0x022081B3)
    send(32'h022081B3);
    nxt();
    chk("f7_cause", 32'(bus.trap_cause), 32'd1);
    clear_trap();

    // ADDI x0,x0,1: no register write, still retires
    send(32'h00100013);
    nxt();
    chk("addi_src", 32'(bus.alu_src), 32'd1);
    nxt();
    chk("addi_rfwen", 32'(bus.rf_wen), 32'd0);
    chk("addi_pcw",   32'(bus.pc_wen), 32'd1);
    nxt();
    chk("addi_instret", bus.instret, 32'd7);

    // SRA x3,x1,x2
    send(32'h4020D1B3);
    nxt();
    chk("sra_alu", 32'(bus.alu_ctrl), 32'(ALU_SRA));
    nxt();
    nxt();
    chk("sra_instret", bus.instret, 32'd8);

    // JAL x1
    send(32'h008000EF);
    nxt();
    nxt();
    chk("jal_rfwen", 32'(bus.rf_wen), 32'd1);
    chk("jal_wbsel", 32'(bus.wb_sel), 32'd2);
    chk("jal_pcsel", 32'(bus.pc_sel), 32'd2);
    nxt();
    chk("jal_instret", bus.instret, 32'd9);

    // Reset asserted mid-MEM aborts immediately
    send(32'h0000A283);
    nxt();
    nxt();
    chk("rstmem_req_pre", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmem_req",     32'(bus.mem_req), 32'd0);
    chk("rstmem_ready",   32'(bus.instr_ready), 32'd1);
    chk("rstmem_instret", bus.instret, 32'd0);
    chk("rstmem_rs1",     32'(bus.rs1_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Retire counter wrap from all-ones
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap_preset", bus.instret, 32'hFFFF_FFFF);
    send(32'h002081B3);
    nxt();
    nxt();
    chk("wrap_wb", bus.instret, 32'hFFFF_FFFF);
    nxt();
    chk("wrap_zero", bus.instret, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
